// File: rtl/rambam_unmask.sv
// rambam_unmask: strips the RAMBAM redundancy from an (8+d)-bit masked byte by
// reducing it modulo P(x)=0x11B, one polynomial bit per clock, with
// valid/ready handshakes on both sides.
`ifndef RAMBAM_D
`define RAMBAM_D 2
`endif

module rambam_unmask #(
    parameter int d = `RAMBAM_D
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7+d:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [7:0]     out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    localparam int W  = 8 + d;
    localparam int CW = (d >= 1) ? $clog2(d + 1) : 1;

    // Redundancy degrees outside 1..8 are not supported.
    if (d < 1 || d > 8) begin : g_bad_d
        $error("rambam_unmask: parameter d must be in 1..8");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;

    // Reduction step for the current bit index k = 8 + cnt.
    logic [W-1:0]    bit_mask;
    logic [W-1:0]    poly_sh;
    logic [W-1:0]    acc_red;

    // One GF(2) long-division step: clear acc[k] by XORing in the shifted P(x).
    always_comb begin
        bit_mask = W'(9'h100) << cnt_q;
        poly_sh  = W'(9'h11B) << cnt_q;
        acc_red  = (|(acc_q & bit_mask)) ? (acc_q ^ poly_sh) : acc_q;
    end

    // Next-state and datapath control; defaults hold every register.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    cnt_d   = CW'(d - 1);
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                acc_d = acc_red;
                if (cnt_q == '0) begin
                    out_data_d  = acc_red[7:0];
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                // out_data stays put after the handoff; only valid drops.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any byte in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == REDUCE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Once reduction finishes, nothing may remain above bit 7.
    a_reduced: assert property (@(posedge clk) disable iff (!rst)
        (state_q == HOLD) |-> (acc_q[W-1:8] == '0));

endmodule
